// File: rtl/hier_resp_merge_pkg.sv
// rtl/hier_resp_merge_pkg.sv - shared types and index-width helper for the response merge node
package hier_pkg;

    localparam int NUM_CHILD_DEF = 5;
    localparam int DATA_W_DEF    = 32;

    // Index width never drops below one bit so single-bit ids stay legal.
    function automatic int child_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHILD_IDX_W = child_idx_w(NUM_CHILD_DEF);

    typedef logic [CHILD_IDX_W-1:0] child_idx_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        child_idx_t            id;
    } resp_beat_t;

endpackage

// File: rtl/hier_rr_arbiter.sv
// rtl/hier_rr_arbiter.sv - round-robin pick of the first requester at or after the pointer
module hier_rr_arbiter #(
    parameter int NUM_CHILD = 5,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_CHILD-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CHILD-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    int best_dist;

    // Distance from the pointer with wrap; the smallest distance among requesters wins.
    always_comb begin
        grant_o   = '0;
        idx_o     = '0;
        valid_o   = 1'b0;
        best_dist = NUM_CHILD;
        for (int j = 0; j < NUM_CHILD; j++) begin
            if (req_i[j] && (((j + NUM_CHILD - int'(ptr_i)) % NUM_CHILD) < best_dist)) begin
                best_dist = (j + NUM_CHILD - int'(ptr_i)) % NUM_CHILD;
                idx_o     = IDX_W'(j);
                valid_o   = 1'b1;
            end
        end
        if (valid_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/hier_resp_merge.sv
// rtl/hier_resp_merge.sv - merges child response beats into one registered parent channel
module hier_resp_merge
    import hier_pkg::*;
#(
    parameter int  NUM_CHILD = 5,
    parameter int  DATA_W    = 32,
    parameter int  CNT_W     = 16,
    localparam int IDX_W     = child_idx_w(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        child_valid,
    output logic [NUM_CHILD-1:0]        child_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic                        parent_valid,
    input  logic                        parent_ready,
    output logic [DATA_W-1:0]           parent_data,
    output logic [IDX_W-1:0]            parent_id,
    output logic [CNT_W-1:0]            beat_cnt,
    output logic                        busy
);

    logic [NUM_CHILD-1:0] grant;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 can_load;
    logic                 load;
    logic                 drain;
    logic [DATA_W-1:0]    data_sel;

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 full_q, full_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    hier_rr_arbiter #(
        .NUM_CHILD (NUM_CHILD),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req_i   (child_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    // A slot is free when empty or when the held beat leaves on this same edge.
    assign can_load    = !full_q || parent_ready;
    assign load        = gnt_vld && can_load && rst_n;
    assign drain       = full_q && parent_ready;
    assign child_ready = (can_load && rst_n) ? grant : '0;

    always_comb begin
        data_sel = '0;
        for (int j = 0; j < NUM_CHILD; j++) begin
            if (gnt_idx == IDX_W'(j)) begin
                data_sel = child_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        full_d = full_q;
        data_d = data_q;
        id_d   = id_q;
        cnt_d  = cnt_q;
        if (drain && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load) begin
            full_d = 1'b1;
            data_d = data_sel;
            id_d   = gnt_idx;
            ptr_d  = (gnt_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            full_q <= full_d;
            data_q <= data_d;
            id_q   <= id_d;
            cnt_q  <= cnt_d;
        end
    end

    assign parent_valid = full_q;
    assign parent_data  = data_q;
    assign parent_id    = id_q;
    assign beat_cnt     = cnt_q;
    assign busy         = full_q;

endmodule
